// File: rtl/seq_muldiv_if.sv
// Operand/result bundle between the register-file read ports, the control FSM and seq_muldiv.
// The master drives operands and start_L; the slave (the unit) returns status and results.
interface seq_muldiv_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opDiv;
    logic             start_L;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;
    logic             divZero;

    modport master (
        output opA, opB, opDiv, start_L,
        input  busy, done, resHi, resLo, divZero
    );

    modport slave (
        input  opA, opB, opDiv, start_L,
        output busy, done, resHi, resLo, divZero
    );
endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one result bit per clock.
// The {hi,lo} pair is the working register and doubles as the visible result.
module seq_muldiv #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic            clock,
    input  logic            reset_L,
    seq_muldiv_if.slave     bus,
    output logic [1:0]      dbg_state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] rem_low;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // Handshake: start_L is sampled low in IDLE or DONE to accept an operation; busy is
    // high for the whole RUN phase; done is a one-cycle pulse during which results are final.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // Shifted partial remainder is {hi_q, lo_q msb}; its top bit alone guarantees it exceeds the divisor.
        rem_low = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        rem_ge  = hi_q[WIDTH-1] | (rem_low >= opnd_q);
        rem_sub = rem_low - opnd_q;

        case (state_q)
            IDLE, DONE: begin
                if (!bus.start_L) begin
                    opnd_d = bus.opDiv ? bus.opB : bus.opA;
                    div_d  = bus.opDiv;
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    if (bus.opDiv && (bus.opB == '0)) begin
                        hi_d    = bus.opA;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = bus.opDiv ? bus.opA : bus.opB;
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (div_q) begin
                    hi_d = rem_ge ? rem_sub : rem_low;
                    lo_d = {lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.resHi   = hi_q;
    assign bus.resLo   = lo_q;
    assign bus.divZero = dz_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: directed scenarios plus random operations checked every cycle
// against an arithmetic model of results and of the busy/done timing.
module tb_seq_muldiv;
  localparam int W = 16;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic [1:0] dbg_state;

  seq_muldiv_if #(.WIDTH(W)) bus ();

  seq_muldiv #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // model state: {divZero, resHi, resLo} expected per accepted operation
  logic [2*W:0] exp_q[$];
  logic         pend = 1'b0;
  int           p_e0 = 0;
  logic         p_dz = 1'b0;
  logic [2*W:0] last_res = '0;

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic div);
    logic [2*W-1:0] p;
    if (div) begin
      if (b == '0) return {1'b1, a, {W{1'b1}}};
      return {1'b0, W'(a % b), W'(a / b)};
    end
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return {1'b0, p};
  endfunction

  task automatic check(input string name, input logic [2*W:0] got, input logic [2*W:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic exp_busy;
    logic exp_done;
    exp_busy = pend && !p_dz && (cyc >= p_e0) && (cyc < p_e0 + W);
    exp_done = pend && (cyc == p_e0 + (p_dz ? 0 : W));
    check("busy", {{(2*W){1'b0}}, bus.busy}, {{(2*W){1'b0}}, exp_busy});
    check("done", {{(2*W){1'b0}}, bus.done}, {{(2*W){1'b0}}, exp_done});
    if (exp_done && exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      pend = 1'b0;
      check("result", {bus.divZero, bus.resHi, bus.resLo}, last_res);
    end else if (!pend) begin
      check("hold", {bus.divZero, bus.resHi, bus.resLo}, last_res);
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic div);
    bus.opA     = a;
    bus.opB     = b;
    bus.opDiv   = div;
    bus.start_L = 1'b0;
    pend = 1'b1;
    p_e0 = cyc + 1;
    p_dz = div && (b == '0);
    exp_q.push_back(model(a, b, div));
    step();
    bus.start_L = 1'b1;
  endtask

  // Runs until the model says the operation is complete; operands are scrambled meanwhile.
  task automatic finish_op();
    int n;
    n = 0;
    while (pend && n < 40) begin
      bus.opA   = W'($urandom);
      bus.opB   = W'($urandom);
      bus.opDiv = 1'($urandom);
      step();
      n++;
    end
    if (pend) begin
      tests++;
      fails++;
      $display("FAIL timeout at cycle %0d: done not seen, expected by cycle %0d", cyc, p_e0 + W);
      pend = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic apply_reset_midway();
    reset_L = 1'b0;
    #1;
    check("rst_busy",    {{(2*W){1'b0}}, bus.busy},    '0);
    check("rst_done",    {{(2*W){1'b0}}, bus.done},    '0);
    check("rst_resHi",   {{(W+1){1'b0}}, bus.resHi},   '0);
    check("rst_resLo",   {{(W+1){1'b0}}, bus.resLo},   '0);
    check("rst_divZero", {{(2*W){1'b0}}, bus.divZero}, '0);
    pend = 1'b0;
    exp_q.delete();
    last_res = '0;
    step();
    step();
    reset_L = 1'b1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         div;
    int           gap;

    bus.opA     = '0;
    bus.opB     = '0;
    bus.opDiv   = 1'b0;
    bus.start_L = 1'b1;

    // model pins
    check("pin_mul", model(16'h1234, 16'h5678, 1'b0), {1'b0, 32'h0626_0060});
    check("pin_div", model(16'h03E8, 16'h0007, 1'b1), {1'b0, 16'h0006, 16'h008E});
    check("pin_dz",  model(16'h00AB, 16'h0000, 1'b1), {1'b1, 16'h00AB, 16'hFFFF});

    // reset state
    apply_reset_midway();

    do_op(16'h1234, 16'h5678, 1'b0);
    finish_op();
    check("lit_mul_1234", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0626, 16'h0060});
    step();

    do_op(16'hFFFF, 16'hFFFF, 1'b0);
    finish_op();
    check("lit_mul_ffff", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'hFFFE, 16'h0001});
    do_op(16'h03E8, 16'h0007, 1'b1);
    finish_op();
    check("lit_div_1000_7", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0006, 16'h008E});
    step();
    step();

    do_op(16'h00AB, 16'h0000, 1'b1);
    finish_op();
    check("lit_div_zero", {bus.divZero, bus.resHi, bus.resLo}, {1'b1, 16'h00AB, 16'hFFFF});
    step();
    do_op(16'h0002, 16'h0003, 1'b0);
    finish_op();
    check("lit_mul_2x3", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0000, 16'h0006});
    step();

    // start strobe during RUN must be ignored
    do_op(16'h0003, 16'h0005, 1'b0);
    repeat (4) step();
    bus.opA     = 16'hFFFF;
    bus.opB     = 16'hFFFF;
    bus.start_L = 1'b0;
    step();
    bus.start_L = 1'b1;
    finish_op();
    check("lit_mul_3x5", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0000, 16'h000F});
    step();
    step();

    // reset abandons an operation in flight
    do_op(16'h8000, 16'h0003, 1'b1);
    repeat (7) step();
    apply_reset_midway();
    do_op(16'h8000, 16'h0003, 1'b1);
    finish_op();
    check("lit_div_8000_3", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0002, 16'h2AAA});
    step();

    do_op(16'h0005, 16'h0009, 1'b1);
    finish_op();
    repeat (10) step();
    check("lit_div_5_9_hold", {bus.divZero, bus.resHi, bus.resLo}, {1'b0, 16'h0005, 16'h0000});

    // random operations, back-to-back or with idle gaps
    for (int i = 0; i < 150; i++) begin
      a   = W'($urandom);
      div = 1'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = {1'b1, W'($urandom) >> 1};
        default: b = W'($urandom);
      endcase
      do_op(a, b, div);
      finish_op();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Iterative unsigned multiply/divide unit directly downstream of the register file.
- Consumes the two register read ports (outA, outB) as operands.
- Produces a double-width product or a quotient/remainder pair that the datapath writes back through the register file input.
- One result bit per clock; start/busy/done handshake so the control FSM can stall while it runs.

Parameters:
WIDTH, 16, operand width in bits; also the iteration count.
CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
clock  input  1  system clock, rising-edge.
reset_L  input  1  asynchronous, active-low reset.
opA  input  WIDTH  multiplicand / dividend (from register file outA).
opB  input  WIDTH  multiplier / divisor (from register file outB).
opDiv  input  1  0 = multiply, 1 = divide; sampled with start_L.
start_L  input  1  active-low start strobe; sampled on rising edge.
busy  output  1  high while iterating (RUN state).
done  output  1  one-cycle pulse; results valid.
resHi  output  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
resLo  output  WIDTH  MUL: product[W-1:0]; DIV: quotient.
divZero  output  1  set when a divide with opB == 0 completes.

Behaviour:
Interface:
- One clock. Reset is asynchronous and active-low, named clock and reset_L as elsewhere in the processor.

Reset:
- reset_L low forces state=IDLE immediately, regardless of clock.
- busy=0, done=0, resHi=0, resLo=0, divZero=0; counter and internal operand registers cleared.
- Reset mid-operation abandons the operation; no done pulse is produced.

FSM states: IDLE, RUN, DONE.

IDLE:
- start_L==0 at edge E0: latch opA, opB, opDiv; clear counter and divZero.
- Normal case: go to RUN.
- Divide with opB==0: go directly to DONE with resLo={WIDTH{1}}, resHi=opA, divZero=1. done is high in the cycle after E0 (latency 1).

RUN:
- busy=1. One iteration per edge; counter counts 0..WIDTH-1.
- On the edge with counter==WIDTH-1: perform the final iteration and go to DONE.
- start_L is ignored. opA/opB/opDiv changes are ignored because operands are latched.

DONE:
- done=1 and busy=0 for exactly one cycle; resHi/resLo hold the final values.
- Next edge: start_L==0 starts a new operation exactly as from IDLE (back-to-back); otherwise go to IDLE.

Latency:
- Start accepted at E0; iterations on E1..E16 (WIDTH=16); done high between E16 and E17.

Result hold:
- resHi/resLo/divZero hold their values after DONE until the next accepted start.
- During RUN they expose internal partial values; downstream must sample only when done=1.

MUL arithmetic (shift-add, unsigned):
- {resHi,resLo} = opA*opB, full 2*WIDTH bits; no overflow possible.

DIV arithmetic (restoring, unsigned):
- quotient = floor(opA/opB), remainder = opA mod opB.
- Remainder is always < opB.
- opA < opB gives quotient 0, remainder opA.

Test Plan:
- MUL opA=0x1234, opB=0x5678, start at E0 -> done pulse exactly at E16, busy high E1..E16, resHi=0x0626, resLo=0x0060, divZero=0.
- MUL 0xFFFF*0xFFFF -> resHi=0xFFFE, resLo=0x0001; then DIV 0x03E8/0x0007 issued back-to-back while done=1 -> resLo=0x008E, resHi=0x0006, second done 16 cycles later.
- DIV 0x00AB/0x0000 -> done one cycle after accept, resLo=0xFFFF, resHi=0x00AB, divZero=1; a following MUL 2*3 clears divZero, resLo=0x0006.
- MUL 0x0003*0x0005 started; at RUN cycle 5 drive start_L=0 with opA=0xFFFF, opB=0xFFFF -> single done at E16, resLo=0x000F, resHi=0x0000.
- DIV 0x8000/0x0003 started; reset_L low at RUN cycle 8 -> busy, done, resHi, resLo, divZero all 0 immediately, no done pulse; after release, DIV 0x8000/0x0003 -> resLo=0x2AAA, resHi=0x0002.
- DIV 0x0005/0x0009 -> resLo=0x0000, resHi=0x0005; outputs remain stable for 10 idle cycles afterward.
